// File: rtl/block_mover_if.sv
// Player/verdict handshake and block-span bundle between block_mover
// and its neighbours (stop button, find_intersection, renderer).
interface block_mover_if;
  logic       stop_btn;
  logic       intersect_true;
  logic       done_finding;
  logic       stop_true;
  logic       reset_intersect_true;
  logic [8:0] curr_block_start;
  logic [8:0] curr_block_end;
  logic [8:0] prev_block_start;
  logic [8:0] prev_block_end;
  logic [3:0] curr_block_size;
  logic [3:0] prev_block_size;
  logic [3:0] row;
  logic       game_over;
  logic       win;

  modport master (
    input  stop_btn, intersect_true, done_finding,
    output stop_true, reset_intersect_true,
    output curr_block_start, curr_block_end,
    output prev_block_start, prev_block_end,
    output curr_block_size, prev_block_size,
    output row, game_over, win
  );

  modport slave (
    output stop_btn, intersect_true, done_finding,
    input  stop_true, reset_intersect_true,
    input  curr_block_start, curr_block_end,
    input  prev_block_start, prev_block_end,
    input  curr_block_size, prev_block_size,
    input  row, game_over, win
  );
endinterface

// File: rtl/block_mover.sv
// Block-stacker moving block: bounces left/right, latches on stop,
// waits for the intersection verdict, then advances, wins or ends.
module block_mover #(
  parameter logic [8:0]  X_MAX     = 9'd159,
  parameter logic [8:0]  UNIT      = 9'd8,
  parameter logic [3:0]  INIT_SIZE = 4'd4,
  parameter logic [23:0] TICK_DIV  = 24'd5000000,
  parameter logic [3:0]  ROWS      = 4'd15
) (
  input  logic          clk,
  input  logic          resetn,
  block_mover_if.master bus
);

  localparam logic [8:0] SPAN =
    {5'd0, INIT_SIZE} * UNIT - 9'd1;

  typedef enum logic [2:0] {
    MOVE, STOP, NEXT, OVER, WIN
  } state_t;

  state_t      state, state_d;
  logic        left, left_d;
  logic [23:0] cnt, cnt_d;
  logic [8:0]  start, start_d;
  logic [8:0]  cend;
  logic [8:0]  pstart, pstart_d;
  logic [8:0]  pend, pend_d;
  logic [3:0]  row, row_d;
  logic        stop_true, rit;
  logic        game_over, win;
  logic        btn_q;
  logic        stop_edge, tick;

  assign stop_edge = bus.stop_btn & ~btn_q;
  assign tick      = (cnt == TICK_DIV - 24'd1);

  always_comb begin
    state_d  = state;
    left_d   = left;
    cnt_d    = cnt;
    start_d  = start;
    pstart_d = pstart;
    pend_d   = pend;
    row_d    = row;
    unique case (state)
      MOVE: begin
        cnt_d = tick ? 24'd0 : cnt + 24'd1;
        // a stop edge beats a simultaneous tick
        if (stop_edge) begin
          state_d = STOP;
        end else if (tick) begin
          if (!left) begin
            if ({1'b0, cend} + {1'b0, UNIT} <= {1'b0, X_MAX}) begin
              start_d = start + UNIT;
            end else begin
              left_d  = 1'b1;
              start_d = start - UNIT;
            end
          end else begin
            if (start >= UNIT) begin
              start_d = start - UNIT;
            end else begin
              left_d  = 1'b0;
              start_d = start + UNIT;
            end
          end
        end
      end
      STOP: begin
        if (bus.done_finding) begin
          if (bus.intersect_true) begin
            pstart_d = start;
            pend_d   = cend;
            if (row == ROWS - 4'd1) begin
              state_d = WIN;
            end else begin
              row_d   = row + 4'd1;
              state_d = NEXT;
            end
          end else begin
            state_d = OVER;
          end
        end
      end
      NEXT: begin
        start_d = 9'd0;
        left_d  = 1'b0;
        cnt_d   = 24'd0;
        state_d = MOVE;
      end
      OVER: ;
      WIN:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state     <= MOVE;
      left      <= 1'b0;
      cnt       <= 24'd0;
      start     <= 9'd0;
      cend      <= SPAN;
      pstart    <= 9'd0;
      pend      <= 9'd0;
      row       <= 4'd0;
      stop_true <= 1'b0;
      rit       <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
      btn_q     <= 1'b1;
    end else begin
      state     <= state_d;
      left      <= left_d;
      cnt       <= cnt_d;
      start     <= start_d;
      cend      <= start_d + SPAN;
      pstart    <= pstart_d;
      pend      <= pend_d;
      row       <= row_d;
      stop_true <= (state_d == STOP);
      rit       <= (state_d == NEXT);
      game_over <= (state_d == OVER);
      win       <= (state_d == WIN);
      btn_q     <= bus.stop_btn;
    end
  end

  assign bus.stop_true            = stop_true;
  assign bus.reset_intersect_true = rit;
  assign bus.curr_block_start     = start;
  assign bus.curr_block_end       = cend;
  assign bus.prev_block_start     = pstart;
  assign bus.prev_block_end       = pend;
  assign bus.curr_block_size      = INIT_SIZE;
  assign bus.prev_block_size      = INIT_SIZE;
  assign bus.row                  = row;
  assign bus.game_over            = game_over;
  assign bus.win                  = win;

endmodule
